alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16, data width of operands and result.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation from requester k is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  DW  operands A and B.
REQ-007 SHALL have ports req0_c / req1_c  input  1  carry-in for opcode 2.
REQ-008 SHALL have ports req0_opc / req1_opc  input  3  ALU opcode, 0..7.
REQ-009 SHALL have port rsp_valid  output  1  result registers hold a valid result.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port rsp_w  output  DW  ALU result.
REQ-012 SHALL have ports rsp_zer, rsp_neg  output  1  flags: result==0, result MSB.
REQ-013 SHALL have port rsp_id  output  1  index of requester that owns the result.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqk_valid, SHALL grant exactly one requester, assert only its reqk_ready combinationally in that cycle, capture its a/b/c/opc and id into operand registers, and go to EXEC; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: pointer selects preferred requester; if only one valid, it wins regardless of pointer.
REQ-017 Pointer SHALL update on grant to the requester not granted.
REQ-018 reqk_ready SHALL be 0 in EXEC and RESP, and 0 for a requester whose valid is 0.
REQ-019 EXEC: ALU SHALL evaluate captured operands combinationally; rsp_w/rsp_zer/rsp_neg/rsp_id SHALL be registered at the end of EXEC, rsp_valid set, state goes to RESP.
REQ-020 ALU function per opcode: 0 two's-complement negate of A; 1 A+1; 2 A+B+C; 3 A + (B arithmetic-shift-right 1); 4 A&B; 5 A|B; 6 {A[7:0],B[7:0]}; 7 zero; all sums truncated to DW bits, carry-out discarded.
REQ-021 rsp_zer SHALL equal (rsp_w==0); rsp_neg SHALL equal rsp_w[DW-1].
REQ-022 RESP: outputs SHALL hold stable while rsp_ready=0; on rsp_valid&rsp_ready, rsp_valid SHALL clear and state returns to IDLE next cycle.
REQ-023 Latency: grant in cycle N -> rsp_valid high in cycle N+2; minimum 3 cycles between successive grants.
REQ-024 Operands SHALL be sampled only on grant cycle; later changes of requester inputs SHALL not affect the result.
REQ-025 Both valids in same cycle: pointer-preferred requester wins; the other remains pending and SHALL be granted at next IDLE if still valid.
REQ-026 rsp_w/flags/rsp_id SHALL retain last values after handshake until overwritten.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, pointer to requester 0, operand registers 0, rsp_valid 0, rsp_w 0, rsp_zer 0, rsp_neg 0, rsp_id 0.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid after release until a new grant.
REQ-029 reqk_ready SHALL be 0 while rst_n is low.

Structure
REQ-030 Shared package alu_arb_pkg SHALL hold the FSM state enum, the opcode enum (NEG, INC, ADDC, ADDSHR, AND, OR, CAT, ZERO), and default width constant 16.
REQ-031 The ALU datapath SHALL be a sub-module alu_core (pure combinational, opcode-decoded), instantiated once.

Verification
REQ-032 Req0 opc=2 A=0x0005 B=0x0003 C=1 -> rsp_w=0x0009, zer=0, neg=0, id=0, rsp_valid two cycles after grant.
REQ-033 Req1 opc=0 A=0x0001 -> rsp_w=0xFFFF, neg=1, zer=0, id=1; opc=3 A=0x0010 B=0x8000 -> rsp_w=0xC010.
REQ-034 After reset both valid continuously with opc=6 A=0x12AB/B=0x34CD (req0), opc=7 (req1) -> grants alternate 0,1,0,1; results 0xABCD then 0x0000 with zer=1.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_w stable, both reqk_ready 0, no new grant until handshake.
REQ-036 rst_n pulsed low during EXEC -> all outputs 0 immediately, no result emitted, next grant goes to requester 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   DW_DEFAULT : default operand/result width
//   state_e    : arbiter FSM states (IDLE, EXEC, RESP)
//   opc_e      : ALU opcodes 0..7
package alu_arb_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    NEG    = 3'd0,
    INC    = 3'd1,
    ADDC   = 3'd2,
    ADDSHR = 3'd3,
    AND    = 3'd4,
    OR     = 3'd5,
    CAT    = 3'd6,
    ZERO   = 3'd7
  } opc_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational, opcode-decoded ALU.
//   a, b : operands (DW bits, DW >= 16 assumed for the CAT opcode)
//   c    : carry-in, used by ADDC only
//   opc  : operation select
//   w    : result, sums truncated to DW bits
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          c,
  input  opc_e          opc,
  output logic [DW-1:0] w
);

  logic signed [DW-1:0] a_s;
  logic signed [DW-1:0] b_s;
  logic signed [DW-1:0] w_s;

  assign a_s = signed'(a);
  assign b_s = signed'(b);
  assign w   = unsigned'(w_s);

  // Every adder path goes through here so the carry-out is dropped in one place.
  function automatic logic signed [DW-1:0] wrap_add(input logic signed [DW-1:0] x,
                                                    input logic signed [DW-1:0] y,
                                                    input logic                 cin);
    logic [DW:0] full;
    full = {x[DW-1], x} + {y[DW-1], y} + {{DW{1'b0}}, cin};
    return signed'(full[DW-1:0]);
  endfunction

  always_comb begin
    w_s = '0;
    unique case (opc)
      NEG:     w_s = wrap_add(~a_s, '0, 1'b1);
      INC:     w_s = wrap_add(a_s, '0, 1'b1);
      ADDC:    w_s = wrap_add(a_s, b_s, c);
      ADDSHR:  w_s = wrap_add(a_s, b_s >>> 1, 1'b0);
      AND:     w_s = a_s & b_s;
      OR:      w_s = a_s | b_s;
      CAT:     w_s = signed'(DW'({a[7:0], b[7:0]}));
      ZERO:    w_s = '0;
      default: w_s = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU.
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqK_valid/ready      : request handshake for requester K (0/1); ready is
//                           combinational and only high in IDLE for the winner
//   reqK_a/b/c/opc        : operands, carry-in and opcode of requester K
//   rsp_valid/ready       : result handshake
//   rsp_w/zer/neg/id      : result, zero flag, sign flag, owning requester
// One operation is in flight at a time: grant (IDLE) -> compute (EXEC) ->
// hold result until accepted (RESP).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req0_c,
  input  logic [2:0]    req0_opc,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic          req1_c,
  input  logic [2:0]    req1_opc,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_w,
  output logic          rsp_zer,
  output logic          rsp_neg,
  output logic          rsp_id
);

  state_e        state_q;
  state_e        state_d;
  logic          ptr_q;     // preferred requester when both are valid
  logic          any_vld;
  logic          pick1;
  logic          grant;
  logic [DW-1:0] a_p0;
  logic [DW-1:0] b_p0;
  logic          c_p0;
  opc_e          opc_p0;
  logic          id_p0;
  logic [DW-1:0] alu_w;

  assign any_vld = req0_valid | req1_valid;
  // Requester 1 wins if it is the only one asking, or if both ask and it is preferred.
  assign pick1   = req1_valid & (~req0_valid | ptr_q);
  // rst_n gating keeps both readies low for the whole reset window.
  assign grant   = rst_n & (state_q == IDLE) & any_vld;

  assign req0_ready = grant & ~pick1;
  assign req1_ready = grant & pick1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: operand capture on the grant cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      c_p0   <= 1'b0;
      opc_p0 <= NEG;
      id_p0  <= 1'b0;
    end else if (grant) begin
      ptr_q  <= ~pick1;
      a_p0   <= pick1 ? req1_a : req0_a;
      b_p0   <= pick1 ? req1_b : req0_b;
      c_p0   <= pick1 ? req1_c : req0_c;
      opc_p0 <= opc_e'(pick1 ? req1_opc : req0_opc);
      id_p0  <= pick1;
    end
  end

  alu_core #(.DW(DW)) u_alu (
    .a   (a_p0),
    .b   (b_p0),
    .c   (c_p0),
    .opc (opc_p0),
    .w   (alu_w)
  );

  // Stage p1: result registers, loaded at the end of EXEC and held until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_w     <= '0;
      rsp_zer   <= 1'b0;
      rsp_neg   <= 1'b0;
      rsp_id    <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_w     <= alu_w;
      rsp_zer   <= (alu_w == '0);
      rsp_neg   <= alu_w[DW-1];
      rsp_id    <= id_p0;
    end else if ((state_q == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_c, req1_c;
  logic [2:0]    req0_opc, req1_opc;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_w;
  logic          rsp_zer, rsp_neg, rsp_id;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_c     (req0_c),
    .req0_opc   (req0_opc),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_c     (req1_c),
    .req1_opc   (req1_opc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_w      (rsp_w),
    .rsp_zer    (rsp_zer),
    .rsp_neg    (rsp_neg),
    .rsp_id     (rsp_id)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: at most one operation outstanding; its result
  // becomes visible two cycles after the grant and leaves on handshake.
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_gcyc = 0;
  bit          m_ptr = 0;
  logic [15:0] m_res = '0;
  bit          m_rid = 0;
  bit          m_ov = 0;
  logic [15:0] m_ow = '0;
  bit          m_oz = 0, m_on = 0, m_oid = 0;
  int          gq[$];
  logic [15:0] hw[$];
  bit          hz[$];
  int          hid[$];

  logic        s_valid, s_zer, s_neg, s_id, s_r0, s_r1;
  logic [15:0] s_w;
  logic        g0, g1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] m_alu(input logic [2:0] opc, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    logic [31:0] s;
    case (opc)
      3'd0: s = 32'd65536 - 32'(a);
      3'd1: s = 32'(a) + 32'd1;
      3'd2: s = 32'(a) + 32'(b) + 32'(c);
      3'd3: s = 32'(a) + 32'(b) / 32'd2 + (b[15] ? 32'd32768 : 32'd0);
      3'd4: s = 32'(a & b);
      3'd5: s = 32'(a | b);
      3'd6: s = {16'd0, a[7:0], b[7:0]};
      default: s = 32'd0;
    endcase
    return s[15:0];
  endfunction

  // One clock: sample and check at the falling edge, advance the model for
  // the coming rising edge, return just after that edge for new stimulus.
  task automatic tick();
    bit e0, e1, win;
    @(negedge clk);
    cyc++;
    s_valid = rsp_valid; s_w = rsp_w; s_zer = rsp_zer; s_neg = rsp_neg;
    s_id = rsp_id; s_r0 = req0_ready; s_r1 = req1_ready;
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_ov = 0; m_ow = '0; m_oz = 0; m_on = 0; m_oid = 0;
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_w",     32'(s_w),     32'd0);
      chk("rst_zer",   32'(s_zer),   32'd0);
      chk("rst_neg",   32'(s_neg),   32'd0);
      chk("rst_id",    32'(s_id),    32'd0);
      chk("rst_rdy0",  32'(s_r0),    32'd0);
      chk("rst_rdy1",  32'(s_r1),    32'd0);
    end else begin
      if (m_busy && cyc == m_gcyc + 2) begin
        m_ov = 1; m_ow = m_res; m_oz = (m_res == 16'd0); m_on = m_res[15]; m_oid = m_rid;
      end
      e0 = 0; e1 = 0; win = 0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        win = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        e0 = !win; e1 = win;
      end
      chk("rsp_valid", 32'(s_valid), 32'(m_ov));
      chk("rsp_w",     32'(s_w),     32'(m_ow));
      chk("rsp_zer",   32'(s_zer),   32'(m_oz));
      chk("rsp_neg",   32'(s_neg),   32'(m_on));
      chk("rsp_id",    32'(s_id),    32'(m_oid));
      chk("req0_ready", 32'(s_r0),   32'(e0));
      chk("req1_ready", 32'(s_r1),   32'(e1));
      if (e0 || e1) begin
        m_busy = 1; m_gcyc = cyc; m_rid = win; m_ptr = !win;
        m_res = win ? m_alu(req1_opc, req1_a, req1_b, req1_c)
                    : m_alu(req0_opc, req0_a, req0_b, req0_c);
        gq.push_back(int'(win));
      end else if (m_ov && rsp_ready) begin
        m_ov = 0; m_busy = 0;
        hw.push_back(s_w); hz.push_back(s_zer); hid.push_back(int'(s_id));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit k, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [2:0] opc);
    if (k) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_c = c; req1_opc = opc;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_c = c; req0_opc = opc;
    end
  endtask

  // Grant, then scramble the requester's inputs, and stop at the first RESP cycle.
  task automatic run_one(input bit k, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [2:0] opc);
    set_req(k, a, b, c, opc);
    tick();
    g0 = s_r0; g1 = s_r1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_opc = 3'd5;
    req1_a = 16'hDEAD; req1_b = 16'hBEEF; req1_opc = 3'd5;
    tick();
    chk("lit_exec_valid", 32'(s_valid), 32'd0);
    tick();
  endtask

  initial begin
    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_c = 0; req0_opc = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_c = 0; req1_opc = '0;
    tick(); tick();
    rst_n = 1;
    tick();

    // ADDC with carry, latency and id
    run_one(0, 16'h0005, 16'h0003, 1'b1, 3'd2);
    chk("lit_addc_gnt0", 32'(g0), 32'd1);
    chk("lit_addc_gnt1", 32'(g1), 32'd0);
    chk("lit_addc_valid", 32'(s_valid), 32'd1);
    chk("lit_addc_w", 32'(s_w), 32'h0009);
    chk("lit_addc_zer", 32'(s_zer), 32'd0);
    chk("lit_addc_neg", 32'(s_neg), 32'd0);
    chk("lit_addc_id", 32'(s_id), 32'd0);
    tick();
    chk("lit_retain_valid", 32'(s_valid), 32'd0);
    chk("lit_retain_w", 32'(s_w), 32'h0009);

    // NEG and ADDSHR from requester 1
    run_one(1, 16'h0001, 16'h0000, 1'b0, 3'd0);
    chk("lit_neg_w", 32'(s_w), 32'hFFFF);
    chk("lit_neg_neg", 32'(s_neg), 32'd1);
    chk("lit_neg_zer", 32'(s_zer), 32'd0);
    chk("lit_neg_id", 32'(s_id), 32'd1);
    tick();
    run_one(1, 16'h0010, 16'h8000, 1'b0, 3'd3);
    chk("lit_addshr_w", 32'(s_w), 32'hC010);
    tick();

    // wrap-around boundaries and logic ops
    run_one(0, 16'hFFFF, 16'h0000, 1'b1, 3'd2);
    chk("lit_addc_wrap_w", 32'(s_w), 32'h0000);
    chk("lit_addc_wrap_zer", 32'(s_zer), 32'd1);
    tick();
    run_one(0, 16'hFFFF, 16'h0000, 1'b0, 3'd1);
    chk("lit_inc_wrap_w", 32'(s_w), 32'h0000);
    tick();
    run_one(1, 16'h00FF, 16'h0F0F, 1'b0, 3'd5);
    chk("lit_or_w", 32'(s_w), 32'h0FFF);
    tick();
    run_one(0, 16'h8000, 16'h0000, 1'b0, 3'd0);
    chk("lit_neg_min_w", 32'(s_w), 32'h8000);
    tick();

    // Both valid continuously after reset: alternation
    rst_n = 0; tick(); rst_n = 1;
    gq.delete(); hw.delete(); hz.delete(); hid.delete();
    set_req(0, 16'h12AB, 16'h34CD, 1'b0, 3'd6);
    set_req(1, 16'h5555, 16'hAAAA, 1'b1, 3'd7);
    repeat (12) tick();
    req0_valid = 0; req1_valid = 0;
    tick(); tick();
    chk("lit_rr_ngrants", 32'(gq.size() >= 4), 32'd1);
    chk("lit_rr_nresults", 32'(hw.size() >= 3), 32'd1);
    if (gq.size() >= 4) begin
      chk("lit_rr_g0", 32'(gq[0]), 32'd0);
      chk("lit_rr_g1", 32'(gq[1]), 32'd1);
      chk("lit_rr_g2", 32'(gq[2]), 32'd0);
      chk("lit_rr_g3", 32'(gq[3]), 32'd1);
    end
    if (hw.size() >= 3) begin
      chk("lit_rr_w0", 32'(hw[0]), 32'hABCD);
      chk("lit_rr_z0", 32'(hz[0]), 32'd0);
      chk("lit_rr_id0", 32'(hid[0]), 32'd0);
      chk("lit_rr_w1", 32'(hw[1]), 32'h0000);
      chk("lit_rr_z1", 32'(hz[1]), 32'd1);
      chk("lit_rr_id1", 32'(hid[1]), 32'd1);
      chk("lit_rr_w2", 32'(hw[2]), 32'hABCD);
    end

    // Back-pressure in RESP with the other requester waiting
    rsp_ready = 0;
    set_req(0, 16'hF0F0, 16'hFF00, 1'b0, 3'd4);
    tick();
    req0_valid = 0;
    set_req(1, 16'h1234, 16'h0000, 1'b0, 3'd5);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lit_hold_valid", 32'(s_valid), 32'd1);
      chk("lit_hold_w", 32'(s_w), 32'hF000);
      chk("lit_hold_neg", 32'(s_neg), 32'd1);
      chk("lit_hold_rdy0", 32'(s_r0), 32'd0);
      chk("lit_hold_rdy1", 32'(s_r1), 32'd0);
    end
    rsp_ready = 1;
    tick();
    tick();
    chk("lit_after_hold_gnt1", 32'(s_r1), 32'd1);
    req1_valid = 0;
    tick(); tick(); tick();
    chk("lit_pre_rst_w", 32'(s_w), 32'h1234);

    // Reset during EXEC discards the operation and resets the pointer
    set_req(0, 16'h0007, 16'h0000, 1'b0, 3'd1);
    tick();
    req0_valid = 0;
    rst_n = 0;
    req1_valid = 1;
    #1;
    chk("lit_arst_valid", 32'(rsp_valid), 32'd0);
    chk("lit_arst_w", 32'(rsp_w), 32'h0000);
    chk("lit_arst_id", 32'(rsp_id), 32'd0);
    chk("lit_arst_rdy1", 32'(req1_ready), 32'd0);
    tick();
    req1_valid = 0;
    rst_n = 1;
    tick(); tick(); tick();
    chk("lit_no_result_valid", 32'(s_valid), 32'd0);
    set_req(0, 16'h0007, 16'h0000, 1'b0, 3'd1);
    set_req(1, 16'h0100, 16'h0001, 1'b1, 3'd2);
    tick();
    chk("lit_post_rst_gnt0", 32'(s_r0), 32'd1);
    chk("lit_post_rst_gnt1", 32'(s_r1), 32'd0);
    req0_valid = 0; req1_valid = 0;
    tick(); tick();
    chk("lit_post_rst_w", 32'(s_w), 32'h0008);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
